ap_stack: RTL

Parametrised accumulator-pointer select register with a LIFO save/restore stack. It is the next generation of the CPU's pointer-select block: it decodes a set code into a registered select, bounds-checks the code, and saves/restores selects across nested routines. It sits between the control decoder (which issues `ap_op`/`ap_set`) and the register-file read-port muxes (driven by `ap_sel`).

---
 rtl/ap_stack.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ap_stack.sv
// ap_stack: accumulator-pointer select register with a LIFO save/restore stack.
// A set code is range-checked and loaded into a registered select; PUSH saves
// the current select before loading, POP restores the most recently saved one.
// Rejected commands raise a one-cycle error pulse with a cause code.
module ap_stack #(
  parameter int SEL_W   = 3,
  parameter int SET_W   = 4,
  parameter int DEPTH   = 4,
  parameter int RST_SEL = 0,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ap_op,
  input  logic [SET_W-1:0] ap_set,
  output logic [SEL_W-1:0] ap_sel,
  output logic [CNT_W-1:0] ap_depth,
  output logic             ap_full,
  output logic             ap_empty,
  output logic             ap_err,
  output logic [1:0]       ap_err_code
);

  // Pointer width for addressing DEPTH entries; one bit minimum for DEPTH == 1.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_RANGE     = 2'b01,
    ERR_OVERFLOW  = 2'b10,
    ERR_UNDERFLOW = 2'b11
  } err_e;

  logic [SEL_W-1:0] stack [DEPTH];
  logic             in_range;
  logic [PTR_W-1:0] push_ptr;
  logic [PTR_W-1:0] pop_ptr;
  logic [SEL_W-1:0] sel_nxt;
  logic [CNT_W-1:0] depth_nxt;
  err_e             err_nxt;
  err_e             err_code_q;
  logic             push_en;

  // Upper set-code bits must be clear; with equal widths every code is legal.
  generate
    if (SET_W > SEL_W) begin : g_range
      assign in_range = ~|ap_set[SET_W-1:SEL_W];
    end else begin : g_no_range
      assign in_range = 1'b1;
    end
  endgenerate

  // The depth counter doubles as the write pointer; the top entry sits one below.
  // Since depth never exceeds 2**PTR_W, the truncated subtraction is exact.
  assign push_ptr = ap_depth[PTR_W-1:0];
  assign pop_ptr  = push_ptr - PTR_W'(1);

  assign ap_full     = (ap_depth == CNT_W'(DEPTH));
  assign ap_empty    = (ap_depth == '0);
  assign ap_err_code = err_code_q;

  // Decode the command into next select, next depth, stack write and error cause.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    sel_nxt   = ap_sel;
    depth_nxt = ap_depth;
    err_nxt   = ERR_NONE;
    push_en   = 1'b0;
    case (op_e'(ap_op))
      OP_LOAD: begin
        if (in_range) sel_nxt = ap_set[SEL_W-1:0];
        else          err_nxt = ERR_RANGE;
      end
      OP_PUSH: begin
        if (!in_range) begin
          err_nxt = ERR_RANGE;
        end else if (ap_full) begin
          err_nxt = ERR_OVERFLOW;
        end else begin
          push_en   = 1'b1;
          depth_nxt = ap_depth + CNT_W'(1);
          sel_nxt   = ap_set[SEL_W-1:0];
        end
      end
      OP_POP: begin
        if (ap_empty) begin
          err_nxt = ERR_UNDERFLOW;
        end else begin
          depth_nxt = ap_depth - CNT_W'(1);
          sel_nxt   = stack[pop_ptr];
        end
      end
      default: ;
    endcase
  end

  // Architectural state: select, depth and the one-cycle error report.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst) begin
      ap_sel     <= SEL_W'(RST_SEL);
      ap_depth   <= '0;
      ap_err     <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      ap_sel     <= sel_nxt;
      ap_depth   <= depth_nxt;
      ap_err     <= (err_nxt != ERR_NONE);
      err_code_q <= err_nxt;
    end
  end

  // Save the outgoing select on an accepted PUSH.
  always_ff @(posedge clk) begin
    // NOTE: the stack array has no reset; its contents are unreachable until
    // written because depth resets to zero, so resetting it buys nothing.
    if (push_en) stack[push_ptr] <= ap_sel;
  end

endmodule
